// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave over a word SRAM, independent read/write FSMs; AXI_SLVERR_EN flags out-of-range beats with SLVERR
module axi_sram_slave #(
  parameter int MEM_AW   = 14,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int A = MEM_AW + 2;
  localparam logic [31:0] LO = 32'((64'h1 << A) - 64'h1);
`ifdef AXI_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  logic [31:0] mem [2**MEM_AW];
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] sum, wm;
    sum = a + (32'h1 << size);
    wm = (({28'h0, len} + 32'h1) << size) - 32'h1;
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~wm) | (sum & wm) : (a & ~LO) | (sum & LO);
  endfunction
  function automatic logic oor(input logic [31:0] a);
    return SLVERR && ((a & ~LO) != 32'h0);
  endfunction
  r_state_t r_state, r_state_n;
  logic [31:0] r_addr, r_addr_n;
  logic [3:0] r_len, r_cnt, r_cnt_n, r_wait, r_wait_n;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic r_load;
  assign arready = r_state == R_IDLE;
  assign rvalid = r_state == R_DATA;
  assign rlast = rvalid && r_cnt == 4'd0;
  always_comb begin
    r_state_n = r_state;
    r_addr_n = r_addr;
    r_cnt_n = r_cnt;
    r_wait_n = r_wait;
    r_load = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid) begin
        r_addr_n = araddr;
        r_cnt_n = arlen;
        r_wait_n = 4'(READ_LAT - 1);
        r_state_n = READ_LAT == 1 ? R_DATA : R_WAIT;
        r_load = READ_LAT == 1;
      end
      R_WAIT: begin
        r_wait_n = r_wait - 4'd1;
        r_state_n = r_wait == 4'd1 ? R_DATA : R_WAIT;
        r_load = r_wait == 4'd1;
      end
      R_DATA: if (rready) begin
        r_state_n = r_cnt == 4'd0 ? R_IDLE : R_DATA;
        r_addr_n = r_cnt == 4'd0 ? r_addr : nxt(r_addr, r_len, r_size, r_burst);
        r_cnt_n = r_cnt - 4'd1;
        r_load = r_cnt != 4'd0;
      end
      default: r_state_n = R_IDLE;
    endcase
  end
  // rdata is captured at the edge that presents a beat, so a same-cycle write to that word is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr <= '0;
      r_cnt <= '0;
      r_wait <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      rid <= '0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      r_state <= r_state_n;
      r_addr <= r_addr_n;
      r_cnt <= r_cnt_n;
      r_wait <= r_wait_n;
      if (arvalid && arready) begin
        rid <= arid;
        r_len <= arlen;
        r_size <= arsize;
        r_burst <= arburst;
      end
      if (r_load) begin
        rdata <= oor(r_addr_n) ? 32'h0 : mem[r_addr_n[A-1:2]];
        rresp <= oor(r_addr_n) ? 2'b10 : 2'b00;
      end
    end
  end
  w_state_t w_state, w_state_n;
  logic [31:0] w_addr;
  logic [3:0] w_len, w_cnt;
  logic [2:0] w_size;
  logic [1:0] w_burst;
  logic w_err, w_fire;
  assign awready = w_state == W_IDLE;
  assign wready = w_state == W_DATA;
  assign bvalid = w_state == W_RESP;
  assign bresp = {w_err, 1'b0};
  assign w_fire = wready && wvalid;
  always_comb begin
    w_state_n = w_state == W_IDLE ? (awvalid ? W_DATA : W_IDLE) :
                w_state == W_DATA ? (w_fire && (w_cnt == 4'd0 || wlast) ? W_RESP : W_DATA) :
                w_state == W_RESP ? (bready ? W_IDLE : W_RESP) : W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
      bid <= '0;
    end else begin
      w_state <= w_state_n;
      if (awvalid && awready) begin
        bid <= awid;
        w_addr <= awaddr;
        w_len <= awlen;
        w_size <= awsize;
        w_burst <= awburst;
        w_cnt <= awlen;
        w_err <= 1'b0;
      end
      if (w_fire) begin
        w_addr <= nxt(w_addr, w_len, w_size, w_burst);
        w_cnt <= w_cnt - 4'd1;
        w_err <= w_err | oor(w_addr);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_fire && !oor(w_addr))
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[w_addr[A-1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end
  logic unused;
  assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave with hand-computed expectations
module tb_axi_sram_slave;
  localparam int LAT = 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [3:0] arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0] arsize = 3'd2, awsize = 3'd2;
  logic [1:0] arburst = 2'b01, awburst = 2'b01, rresp, bresp;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic rready = 1'b1, bready = 1'b1;
  logic arready, awready, wready, rvalid, rlast, bvalid;
  int checks = 0, errors = 0;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];
  axi_sram_slave #(.MEM_AW(14), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int beats,
                          input bit bstall, input logic [1:0] eresp);
    int n;
    bready = !bstall;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick; n++; end
    chk("awready", awready, 1);
    tick;
    awvalid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = i == beats - 1; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick; n++; end
      chk("wready", wready, 1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick; n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, eresp);
    if (bstall) begin
      repeat (3) begin
        tick;
        chk("bvalid_hold", bvalid, 1);
        chk("awready_during_b", awready, 0);
      end
      bready = 1'b1;
    end
    tick;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat, input logic [1:0] eresp);
    int n;
    rready = 1'b1;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick; n++; end
    chk("arready", arready, 1);
    tick;
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 20) begin tick; n++; end
    chk("read_latency", n, LAT);
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ebuf[i]);
      chk("rlast", rlast, i == int'(len));
      chk("rid", rid, id);
      chk("rresp", rresp, eresp);
      if (i == stall_beat) begin
        rready = 1'b0;
        repeat (5) begin
          tick;
          chk("stall_rvalid", rvalid, 1);
          chk("stall_rdata", rdata, ebuf[i]);
          chk("stall_rlast", rlast, i == int'(len));
        end
        rready = 1'b1;
      end
      tick;
    end
    chk("rvalid_end", rvalid, 0);
    chk("arready_end", arready, 1);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {rid, bid}, 0);
    chk("rst_resp", {rresp, bresp}, 0);
    rst = 1'b0;
    tick;
    wbuf[0] = 32'hDEADBEEF;
    do_write(4'd5, 32'h10, 4'd0, 2'b01, 4'hF, 1, 1'b0, 2'b00);
    ebuf[0] = 32'hDEADBEEF;
    do_read(4'd3, 32'h10, 4'd0, 2'b01, -1, 2'b00);
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    do_write(4'd2, 32'h100, 4'd3, 2'b01, 4'hF, 4, 1'b0, 2'b00);
    ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
    do_read(4'd1, 32'h100, 4'd3, 2'b01, -1, 2'b00);
    ebuf[0] = 32'd3; ebuf[1] = 32'd4; ebuf[2] = 32'd1; ebuf[3] = 32'd2;
    do_read(4'd7, 32'h108, 4'd3, 2'b10, -1, 2'b00);
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    do_write(4'd9, 32'h100, 4'd3, 2'b01, 4'hF, 2, 1'b0, 2'b00);
    ebuf[0] = 32'h55; ebuf[1] = 32'h66; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
    do_read(4'd2, 32'h100, 4'd3, 2'b01, 1, 2'b00);
    wbuf[0] = 32'h11223344;
    do_write(4'd1, 32'h20, 4'd0, 2'b01, 4'hF, 1, 1'b0, 2'b00);
    wbuf[0] = 32'hAABBCCDD;
    do_write(4'd1, 32'h20, 4'd0, 2'b01, 4'b0101, 1, 1'b0, 2'b00);
    ebuf[0] = 32'h11BB33DD;
    do_read(4'd4, 32'h20, 4'd0, 2'b01, -1, 2'b00);
    wbuf[0] = 32'hA; wbuf[1] = 32'hB;
    do_write(4'd6, 32'h30, 4'd1, 2'b00, 4'hF, 2, 1'b0, 2'b00);
    ebuf[0] = 32'hB;
    do_read(4'd6, 32'h30, 4'd0, 2'b01, -1, 2'b00);
    wbuf[0] = 32'h12345678;
    do_write(4'hC, 32'h40, 4'd0, 2'b01, 4'hF, 1, 1'b1, 2'b00);
    ebuf[0] = 32'h12345678;
    do_read(4'hC, 32'h40, 4'd0, 2'b01, -1, 2'b00);
    arid = 4'd4; araddr = 32'h100; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    tick;
    tick;
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_rdata", rdata, 32'd3);
    rready = 1'b0;
    rst = 1'b1;
    tick;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 1);
    chk("mid_rst_rlast", rlast, 0);
    rst = 1'b0;
    ebuf[0] = 32'hDEADBEEF;
    do_read(4'd6, 32'h10, 4'd0, 2'b01, -1, 2'b00);
`ifdef AXI_SLVERR_EN
    ebuf[0] = 32'h0;
    do_read(4'd8, 32'h8000_0000, 4'd0, 2'b01, -1, 2'b10);
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(4'd8, 32'h8000_0010, 4'd0, 2'b01, 4'hF, 1, 1'b0, 2'b10);
    ebuf[0] = 32'hDEADBEEF;
    do_read(4'd8, 32'h10, 4'd0, 2'b01, -1, 2'b00);
`else
    ebuf[0] = 32'hDEADBEEF;
    do_read(4'd8, 32'h0001_0010, 4'd0, 2'b01, -1, 2'b00);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview: AXI3 slave responder backed by an internal word-addressed SRAM model. It serves the 4-bit-ID, 32-bit read/write bursts issued by mycpu_top's master port, and is the far end of that interface in the SoC and simulation benches. It keeps one outstanding read and one outstanding write, and the read and write channels run independently.

Parameters:
MEM_AW, 14, word-address width; memory holds 2^MEM_AW 32-bit words starting at byte address 0
READ_LAT, 1, cycles from AR handshake to first rvalid; legal range 1..15

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
arid/araddr/arlen/arsize/arburst  input  4/32/4/3/2  read address channel
arlock/arcache/arprot, awlock/awcache/awprot  input  2/4/3 each  ignored
arvalid input 1 / arready output 1  AR handshake
rid/rdata/rresp/rlast  output  4/32/2/1  read data channel
rvalid output 1 / rready input 1  R handshake
awid/awaddr/awlen/awsize/awburst  input  4/32/4/3/2  write address channel
awvalid input 1 / awready output 1  AW handshake
wid/wdata/wstrb/wlast  input  4/32/4/1  write data; wid ignored
wvalid input 1 / wready output 1  W handshake
bid/bresp  output  4/2  write response
bvalid output 1 / bready input 1  B handshake

Behaviour:
- Reset: arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rid/bid/rdata=0, rresp/bresp=2'b00. Both FSMs return to IDLE. Memory contents are kept. A burst in flight when reset is asserted is dropped.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - In R_IDLE with arvalid&arready: latch id, addr, len, size, burst; deassert arready; load the wait counter with READ_LAT-1.
  - R_WAIT counts down to 0. When READ_LAT=1, R_WAIT lasts 0 cycles, so rvalid rises the cycle after the AR handshake.
  - In R_DATA: rvalid=1 and rdata=mem[addr[MEM_AW+1:2]]. rdata stays stable until rvalid&rready.
  - On each R handshake: advance the address, decrement the beat count. rlast=1 exactly on beat len+1. After the last handshake, go to R_IDLE and raise arready the next cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - In W_IDLE, awready=1. An AW handshake latches id/addr/len/size/burst and sets wready=1.
  - In W_DATA, each wvalid&wready writes the bytes enabled by wstrb[i] into lane i of the addressed word, then advances the address.
  - Exit W_DATA after len+1 beats, or early if wlast arrives sooner. An early wlast is still responded OKAY. A beat past len without wlast is the last beat.
  - In W_RESP: bvalid=1, bid=latched awid. Hold until bready; awready returns the cycle after the B handshake.
- Address update per beat:
  - INCR (2'b01): addr += (1<<size). Wrap at 2^(MEM_AW+2).
  - FIXED (2'b00): address unchanged.
  - WRAP (2'b10): wrap within a (len+1)*(1<<size) aligned window; len must be 1, 3, 7 or 15.
  - Reserved (2'b11): treated as INCR.
- Out-of-range addresses (bits above MEM_AW+1 nonzero) alias modulo the memory size.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data, and the write completes.
- rresp/bresp are always OKAY unless the optional feature is enabled.

Optional Feature:
AXI_SLVERR_EN
- Defined: a beat whose address has any nonzero bit above MEM_AW+1 gets rresp=2'b10 with rdata=0. A write beat to such an address is suppressed, and bresp=2'b10 if any beat of the burst was out of range.
- Undefined: addresses alias as above and responses are always OKAY.

Test Plan:
- Single write then read: AW addr 0x10, len 0, size 2; W 0xDEADBEEF, wstrb 4'hF -> bvalid, bresp 0, bid=awid. Then AR addr 0x10, id 3 -> rdata 0xDEADBEEF, rid 3, rlast 1, rvalid exactly READ_LAT cycles after the AR handshake.
- INCR burst len 3 at 0x100 writing 1,2,3,4 -> read back returns 1,2,3,4 in order, with rlast only on beat 4.
- WRAP len 3 read starting at 0x108 -> data returned from 0x108, 0x10C, 0x100, 0x104.
- Partial strobe: word 0x20 = 0x11223344, write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- Backpressure: rready low for 5 cycles mid-burst -> rdata/rlast held stable, no beat lost. bready low 3 cycles -> bvalid held and awready stays 0.
- Reset mid-read-burst (after beat 2 of 4) -> next cycle rvalid=0, arready=1. A new AR is accepted normally. With AXI_SLVERR_EN, a read of 0x8000_0000 -> rresp 2'b10.
